// File: rtl/cpu86_mem_model_pkg.sv
// Shared types, request field offsets and byte-enable helpers for the cpu86 memory responder.
package cpu86_mem_model_pkg;

  // Default geometry; the responder itself is parametrised, these match its defaults
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_BE_W   = DEF_DATA_W / 8;

  // Bit offsets of the request fields inside tdata at default geometry, we at the MSB
  localparam int unsigned REQ_WDATA_LSB = 0;
  localparam int unsigned REQ_ADDR_LSB  = REQ_WDATA_LSB + DEF_DATA_W;
  localparam int unsigned REQ_BE_LSB    = REQ_ADDR_LSB + DEF_ADDR_W;
  localparam int unsigned REQ_WE_BIT    = REQ_BE_LSB + DEF_BE_W;
  localparam int unsigned DEF_REQ_W     = REQ_WE_BIT + 1;

  // Request payload at default geometry
  typedef struct packed {
    logic                  we;
    logic [DEF_BE_W-1:0]   be;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

  // Total request width for an arbitrary geometry
  function automatic int unsigned req_width(input int unsigned data_w,
                                            input int unsigned addr_w);
    return 1 + (data_w / 8) + addr_w + data_w;
  endfunction

  // Select one byte lane: new byte when enabled, old byte otherwise
  function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

  // Byte-enable merge of a full word at default geometry
  function automatic logic [DEF_DATA_W-1:0] be_merge(input logic [DEF_DATA_W-1:0] old_w,
                                                     input logic [DEF_DATA_W-1:0] new_w,
                                                     input logic [DEF_BE_W-1:0]   be);
    logic [DEF_DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(DEF_BE_W); b++) begin
      res[8*b +: 8] = lane_merge(old_w[8*b +: 8], new_w[8*b +: 8], be[b]);
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu86_sync_fifo.sv
// First-word fall-through synchronous FIFO used as the read-response queue.
module cpu86_sync_fifo
  import cpu86_mem_model_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointer / occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Storage and pointer registers; storage cleared so data reads zero out of reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/cpu86_mem_resp_model.sv
// Parametrised memory responder: req stream in, read-data stream out, with latency,
// bounded outstanding reads, response backpressure, byte-enable writes and req throttling.
module cpu86_mem_resp_model
  import cpu86_mem_model_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned MAX_OUT      = 4,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  s_axis_req_tvalid_i,
  output logic                                  s_axis_req_tready_o,
  input  logic [1+DATA_W/8+ADDR_W+DATA_W-1:0]   s_axis_req_tdata_i,
  output logic                                  m_axis_res_tvalid_o,
  input  logic                                  m_axis_res_tready_i,
  output logic [DATA_W-1:0]                     m_axis_res_tdata_o
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned REQ_W    = req_width(DATA_W, ADDR_W);
  localparam int unsigned ADDR_LSB = DATA_W;
  localparam int unsigned BE_LSB   = ADDR_LSB + ADDR_W;
  localparam int unsigned WE_BIT   = REQ_W - 1;
  localparam int unsigned WORDS    = 2 ** ADDR_W;
  localparam int unsigned OUT_W    = $clog2(MAX_OUT + 1);
  localparam int unsigned ACC_W    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  // Request field decode
  logic              req_we;
  logic [BE_W-1:0]   req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  assign req_we    = s_axis_req_tdata_i[WE_BIT];
  assign req_be    = s_axis_req_tdata_i[BE_LSB +: BE_W];
  assign req_addr  = s_axis_req_tdata_i[ADDR_LSB +: ADDR_W];
  assign req_wdata = s_axis_req_tdata_i[DATA_W-1:0];

  // Handshake qualifiers
  logic req_fire, rd_fire, wr_fire, res_fire;
  logic fifo_valid;

  assign req_fire = s_axis_req_tvalid_i && s_axis_req_tready_o;
  assign rd_fire  = req_fire && !req_we;
  assign wr_fire  = req_fire && req_we;

  // Responses are suppressed while reset is high so no beat escapes after reset rises
  assign m_axis_res_tvalid_o = fifo_valid && !reset_i;
  assign res_fire            = m_axis_res_tvalid_o && m_axis_res_tready_i;

  // Outstanding-read counter and throttle state
  logic [OUT_W-1:0] out_q, out_d;
  logic [ACC_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             throttle_q, throttle_d;

  // Ready depends only on registered state and reset, never on tvalid or res_tready
  assign s_axis_req_tready_o = !reset_i && (out_q < OUT_W'(MAX_OUT)) && !throttle_q;

  // Memory array: not reset, contents survive a reset pulse
  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rd_word;

  // Reads sample the array in the accept cycle, so a same-cycle-later write cannot overtake
  assign rd_word = mem_q[req_addr];

  // Byte-enable write commit
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (req_be[b]) begin
          mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Latency pipe: the FIFO register supplies the final cycle, so LATENCY-1 stages here
  logic              pipe_push;
  logic [DATA_W-1:0] pipe_data;

  generate
    if (LATENCY <= 1) begin : g_no_pipe
      assign pipe_push = rd_fire;
      assign pipe_data = rd_word;
    end else begin : g_pipe
      localparam int unsigned STAGES = LATENCY - 1;

      logic [STAGES-1:0] vld_q;
      logic [DATA_W-1:0] dat_q [STAGES];

      // Valid shift chain, flushed by reset
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= rd_fire;
          for (int s = 1; s < int'(STAGES); s++) begin
            vld_q[s] <= vld_q[s-1];
          end
        end
      end

      // Data shift chain, qualified by the valid chain
      always_ff @(posedge clk_i) begin
        dat_q[0] <= rd_word;
        for (int s = 1; s < int'(STAGES); s++) begin
          dat_q[s] <= dat_q[s-1];
        end
      end

      assign pipe_push = vld_q[STAGES-1];
      assign pipe_data = dat_q[STAGES-1];
    end
  endgenerate

  // Response queue; occupancy never exceeds outstanding so it cannot overflow
  cpu86_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_OUT)
  ) u_res_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (pipe_push),
    .push_data_i (pipe_data),
    .pop_i       (res_fire),
    .valid_o     (fifo_valid),
    .data_o      (m_axis_res_tdata_o)
  );

  // Outstanding: +1 on read accept, -1 on response handshake
  always_comb begin
    out_d = out_q;
    if (rd_fire && !res_fire) begin
      out_d = out_q + OUT_W'(1);
    end else if (!rd_fire && res_fire) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  // Throttle: every STALL_PERIOD accepts, drop ready for exactly one cycle
  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    throttle_d = 1'b0;
    if ((STALL_PERIOD != 0) && req_fire) begin
      if (acc_cnt_q == ACC_W'(STALL_PERIOD - 1)) begin
        acc_cnt_d  = '0;
        throttle_d = 1'b1;
      end else begin
        acc_cnt_d = acc_cnt_q + ACC_W'(1);
      end
    end
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_q      <= '0;
      acc_cnt_q  <= '0;
      throttle_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      acc_cnt_q  <= acc_cnt_d;
      throttle_q <= throttle_d;
    end
  end

endmodule

// File: tb/tb_cpu86_mem_resp_model.sv
// Randomised and directed bench for cpu86_mem_resp_model with a queue-based reference model.
module tb_cpu86_mem_resp_model;
  import cpu86_mem_model_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 16;
  localparam int unsigned RW   = 1 + DW/8 + AW + DW;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [RW-1:0] req_data;
  logic          req_ready;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  logic          t_valid;
  logic [RW-1:0] t_data;
  logic          t_ready;
  logic          t_res_valid;
  logic          t_res_ready;
  logic [DW-1:0] t_res_data;

  always #5 clk = ~clk;

  cpu86_mem_resp_model #(
    .DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT), .MAX_OUT(MAXO), .STALL_PERIOD(0)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .s_axis_req_tvalid_i(req_valid), .s_axis_req_tready_o(req_ready),
    .s_axis_req_tdata_i(req_data),
    .m_axis_res_tvalid_o(res_valid), .m_axis_res_tready_i(res_ready),
    .m_axis_res_tdata_o(res_data)
  );

  cpu86_mem_resp_model #(
    .DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT), .MAX_OUT(MAXO), .STALL_PERIOD(3)
  ) dut_thr (
    .clk_i(clk), .reset_i(reset),
    .s_axis_req_tvalid_i(t_valid), .s_axis_req_tready_o(t_ready),
    .s_axis_req_tdata_i(t_data),
    .m_axis_res_tvalid_o(t_res_valid), .m_axis_res_tready_i(t_res_ready),
    .m_axis_res_tdata_o(t_res_data)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned acc_cyc  = 0;
  int unsigned rd_acc_cnt = 0;
  bit          rand_en  = 1'b0;

  typedef struct { int unsigned due; logic [DW-1:0] data; } exp_t;
  typedef struct { int unsigned cyc; logic [DW-1:0] data; } beat_t;

  exp_t          mq[$];
  beat_t         got_q[$];
  logic [DW-1:0] mmem [int unsigned];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model and per-cycle comparison, evaluated mid-cycle when everything is stable
  initial begin : compare
    bit          was_reset;
    bit          exp_rdy, exp_v, acc, pop;
    req_t        r;
    logic [DW-1:0] w;
    was_reset = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("req_tready_in_reset", 64'(req_ready), 64'(0));
        check("res_tvalid_in_reset", 64'(res_valid), 64'(0));
        mq.delete();
        was_reset = 1'b1;
      end else begin
        exp_rdy = (mq.size() < MAXO);
        exp_v   = (mq.size() > 0) && (mq[0].due <= cyc);
        check("req_tready", 64'(req_ready), 64'(exp_rdy));
        check("res_tvalid", 64'(res_valid), 64'(exp_v));
        if (exp_v) check("res_tdata", 64'(res_data), 64'(mq[0].data));
        if (was_reset) check("res_tdata_after_reset", 64'(res_data), 64'(0));
        was_reset = 1'b0;
        if (res_valid && res_ready) got_q.push_back('{cyc: cyc, data: res_data});
        pop = exp_v && res_ready;
        acc = req_valid && exp_rdy;
        if (pop) void'(mq.pop_front());
        if (acc) begin
          r = req_data;
          if (r.we) begin
            w = mmem.exists(int'(r.addr)) ? mmem[int'(r.addr)] : '0;
            for (int b = 0; b < 4; b++) if (r.be[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
            mmem[int'(r.addr)] = w;
          end else begin
            mq.push_back('{due: cyc + LAT, data: mmem[int'(r.addr)]});
          end
        end
      end
    end
  end

  // Random response backpressure while enabled
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  // Present one request and hold it until accepted (bounded)
  task automatic send(input bit we, input logic [3:0] be, input logic [15:0] addr,
                      input logic [31:0] wdata);
    req_t        r;
    bit          done;
    int unsigned waited;
    r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
    req_valid = 1'b1;
    req_data  = r;
    done = 1'b0;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        acc_cyc = cyc;
        if (!we) rd_acc_cnt++;
      end else if (++waited > 300) begin
        n_checks++;
        $display("FAIL req_accept_timeout: waited %0d cycles, limit 300", waited);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int unsigned n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_beats(input int unsigned n, input string name);
    int unsigned w;
    w = 0;
    while (got_q.size() < n && w < 200) begin @(posedge clk); #1; w++; end
    if (got_q.size() < n) begin
      n_checks++;
      $display("FAIL %s: got %0d beats, required %0d", name, got_q.size(), n);
    end
  endtask

  initial begin : stim
    int unsigned base, ra, a0, a15;
    req_t        tr;
    req_valid = 1'b0; req_data = '0; res_ready = 1'b1;
    t_valid = 1'b0; t_data = '0; t_res_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'(1));
    check("tdata_after_reset_lit", 64'(res_data), 64'(0));
    @(posedge clk); #1;

    // Known contents for every address touched later
    for (int a = 0; a < 64; a++) send(1'b1, 4'hF, 16'(a), $urandom);
    idle(1);

    // 1: write then read, exact latency
    base = got_q.size();
    send(1'b1, 4'hF, 16'h0010, 32'hDEADBEEF);
    send(1'b0, 4'h0, 16'h0010, 32'h0);
    ra = acc_cyc;
    idle(0);
    wait_beats(base + 1, "t1_beat");
    check("t1_data", 64'(got_q[base].data), 64'h00000000DEADBEEF);
    check("t1_latency", 64'(got_q[base].cyc - ra), 64'(LAT));

    // 2: partial byte-enable write
    base = got_q.size();
    send(1'b1, 4'hF, 16'h0020, 32'h11223344);
    send(1'b1, 4'b0101, 16'h0020, 32'hAABBCCDD);
    send(1'b0, 4'h0, 16'h0020, 32'h0);
    idle(0);
    wait_beats(base + 1, "t2_beat");
    check("t2_data", 64'(got_q[base].data), 64'h0000000011BB33DD);

    // 3: backpressure limits accepted reads to MAX_OUT, order preserved
    for (int i = 0; i < 6; i++) send(1'b1, 4'hF, 16'(16'h0030 + i), 32'h1000 + 32'(i));
    idle(1);
    res_ready = 1'b0;
    base = got_q.size();
    rd_acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 4'h0, 16'(16'h0030 + i), 32'h0);
        idle(0);
      end
      begin
        repeat (12) begin @(posedge clk); #1; end
        @(negedge clk);
        check("t3_accepted", 64'(rd_acc_cnt), 64'(4));
        check("t3_ready_low", 64'(req_ready), 64'(0));
        check("t3_no_beats_held", 64'(got_q.size() - base), 64'(0));
        @(posedge clk); #1;
        res_ready = 1'b1;
      end
    join
    wait_beats(base + 6, "t3_beats");
    idle(4);
    check("t3_beat_count", 64'(got_q.size() - base), 64'(6));
    for (int i = 0; i < 6; i++) check("t3_order", 64'(got_q[base + i].data), 64'(32'h1000 + i));

    // 4: 16 back-to-back reads, full throughput
    base = got_q.size();
    a0 = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 4'h0, 16'(16'h0030 + (i % 6)), 32'h0);
      if (i == 0) a0 = acc_cyc;
    end
    a15 = acc_cyc;
    idle(0);
    wait_beats(base + 16, "t4_beats");
    check("t4_accept_span", 64'(a15 - a0), 64'(15));
    check("t4_beat_span", 64'(got_q[base + 15].cyc - got_q[base].cyc), 64'(15));
    check("t4_first_latency", 64'(got_q[base].cyc - a0), 64'(LAT));
    check("t4_beat7_data", 64'(got_q[base + 7].data), 64'(32'h1001));

    // 6: reset with reads in flight discards them, memory survives
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 4'h0, 16'h0010, 32'h0);
    idle(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    res_ready = 1'b1;
    base = got_q.size();
    idle(10);
    check("t6_no_beats", 64'(got_q.size() - base), 64'(0));
    @(negedge clk);
    check("t6_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    send(1'b0, 4'h0, 16'h0010, 32'h0);
    idle(0);
    wait_beats(base + 1, "t6_beat");
    check("t6_mem_kept", 64'(got_q[base].data), 64'h00000000DEADBEEF);

    // Random traffic against the model
    rand_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom_range(0, 63)), $urandom);
      idle($urandom_range(0, 2));
    end
    rand_en = 1'b0;
    res_ready = 1'b1;
    idle(20);

    // 5: throttled instance, continuous writes -> ready low every 4th cycle
    t_valid = 1'b1;
    tr.we = 1'b1; tr.be = 4'hF; tr.addr = 16'h0001; tr.wdata = $urandom;
    t_data = tr;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t5_ready", 64'(t_ready), 64'((k % 4) != 3));
      check("t5_res_idle", 64'({t_res_valid, t_res_data}), 64'(0));
      @(posedge clk); #1;
      if (t_ready) begin
        tr.addr = 16'($urandom_range(0, 63));
        tr.wdata = $urandom;
        t_data = tr;
      end
    end
    t_valid = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
